// File: rtl/discus_core.sv
// discus_core: 8-bit accumulator CPU with a private 256x8 program/data RAM.
// A host snoop port loads and inspects the RAM and freezes the core while present.
module discus_core (
   input  logic       clk,
   input  logic       reset,
   input  logic       snoop_clk,
   input  logic [7:0] snoopa,
   input  logic [7:0] snoopd,
   output logic [7:0] snoopq,
   input  logic       snoopm,
   input  logic       snoopp
);

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      OPERAND = 3'd2,
      MEMRD   = 3'd3,
      HALTED  = 3'd4
   } state_t;

   localparam logic [7:0] OP_LDI  = 8'h01;
   localparam logic [7:0] OP_ADDI = 8'h02;
   localparam logic [7:0] OP_SUBI = 8'h03;
   localparam logic [7:0] OP_ANDI = 8'h04;
   localparam logic [7:0] OP_ORI  = 8'h05;
   localparam logic [7:0] OP_XORI = 8'h06;
   localparam logic [7:0] OP_LDA  = 8'h08;
   localparam logic [7:0] OP_STA  = 8'h09;
   localparam logic [7:0] OP_ADD  = 8'h0A;
   localparam logic [7:0] OP_JMP  = 8'h0C;
   localparam logic [7:0] OP_JZ   = 8'h0D;
   localparam logic [7:0] OP_JC   = 8'h0E;
   localparam logic [7:0] OP_JNZ  = 8'h0F;
   localparam logic [7:0] OP_INC  = 8'h10;
   localparam logic [7:0] OP_DEC  = 8'h11;
   localparam logic [7:0] OP_SHL  = 8'h12;
   localparam logic [7:0] OP_SHR  = 8'h13;
   localparam logic [7:0] OP_CLR  = 8'h14;
   localparam logic [7:0] OP_HALT = 8'hFF;

   // Contents come from the configuration image (all zeros); reset never touches them.
   logic [7:0] mem [0:255];

   state_t     state;
   logic [7:0] pc;
   logic [7:0] acc;
   logic       c_flag;
   logic       z_flag;
   logic [7:0] ir;
   logic [7:0] rdata;

   logic [7:0] op;
   logic       is_imm;
   logic       is_mem;
   logic       is_jmp;
   logic       has_operand;
   logic       taken;
   logic       commit;
   logic       wr_a;
   logic       wr_c;
   logic [8:0] res9;
   logic [7:0] core_addr;
   logic       core_we;

   logic unused;
   assign unused = snoop_clk;

   // In DECODE the opcode is still on the RAM output; later states use the latched copy.
   always_comb begin
      op          = (state == DECODE) ? rdata : ir;
      is_imm      = (op >= OP_LDI) && (op <= OP_XORI);
      is_mem      = (op == OP_LDA) || (op == OP_ADD);
      is_jmp      = (op >= OP_JMP) && (op <= OP_JNZ);
      has_operand = is_imm || is_mem || is_jmp || (op == OP_STA);

      taken = 1'b0;
      case (op)
         OP_JMP:  taken = 1'b1;
         OP_JZ:   taken = z_flag;
         OP_JC:   taken = c_flag;
         OP_JNZ:  taken = !z_flag;
         default: taken = 1'b0;
      endcase

      res9 = {c_flag, acc};
      wr_a = 1'b0;
      wr_c = 1'b0;
      case (op)
         OP_LDI, OP_LDA: begin res9 = {1'b0, rdata}; wr_a = 1'b1; end
         OP_ADDI, OP_ADD: begin
            res9 = {1'b0, acc} + {1'b0, rdata};
            wr_a = 1'b1;
            wr_c = 1'b1;
         end
         OP_SUBI: begin
            res9 = {1'b0, acc} - {1'b0, rdata};
            wr_a = 1'b1;
            wr_c = 1'b1;
         end
         OP_ANDI: begin res9 = {1'b0, acc & rdata}; wr_a = 1'b1; end
         OP_ORI:  begin res9 = {1'b0, acc | rdata}; wr_a = 1'b1; end
         OP_XORI: begin res9 = {1'b0, acc ^ rdata}; wr_a = 1'b1; end
         OP_INC:  begin res9 = {1'b0, acc + 8'd1}; wr_a = 1'b1; end
         OP_DEC:  begin res9 = {1'b0, acc - 8'd1}; wr_a = 1'b1; end
         OP_SHL:  begin res9 = {acc, 1'b0}; wr_a = 1'b1; wr_c = 1'b1; end
         OP_SHR:  begin res9 = {acc[0], 1'b0, acc[7:1]}; wr_a = 1'b1; wr_c = 1'b1; end
         OP_CLR:  begin res9 = 9'h000; wr_a = 1'b1; end
         default: begin res9 = {c_flag, acc}; wr_a = 1'b0; wr_c = 1'b0; end
      endcase

      case (state)
         DECODE:  commit = !has_operand && (op != OP_HALT);
         OPERAND: commit = is_imm;
         MEMRD:   commit = 1'b1;
         default: commit = 1'b0;
      endcase

      core_addr = ((state == FETCH) || (state == DECODE)) ? pc : rdata;
      core_we   = !snoopp && (state == OPERAND) && (op == OP_STA);
   end

   // Single write port: host writes win, and the core is frozen whenever snoopp is high.
   always_ff @(posedge clk) begin
      if (snoopp && !snoopm)
         mem[snoopa] <= snoopd;
      else if (core_we)
         mem[rdata] <= acc;
      if (!snoopp)
         rdata <= mem[core_addr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         snoopq <= 8'h00;
      else if (snoopp && snoopm)
         snoopq <= mem[snoopa];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= FETCH;
         pc     <= 8'h00;
         acc    <= 8'h00;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
         ir     <= 8'h00;
      end else if (!snoopp) begin
         if (commit && wr_a) begin
            acc    <= res9[7:0];
            z_flag <= (res9[7:0] == 8'h00);
         end
         if (commit && wr_c)
            c_flag <= res9[8];
         case (state)
            FETCH: begin
               pc    <= pc + 8'd1;
               state <= DECODE;
            end
            DECODE: begin
               ir <= rdata;
               if (rdata == OP_HALT) begin
                  pc    <= pc - 8'd1;
                  state <= HALTED;
               end else if (has_operand) begin
                  pc    <= pc + 8'd1;
                  state <= OPERAND;
               end else begin
                  state <= FETCH;
               end
            end
            OPERAND: begin
               if (is_jmp && taken)
                  pc <= rdata;
               state <= is_mem ? MEMRD : FETCH;
            end
            MEMRD:   state <= FETCH;
            HALTED:  state <= HALTED;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_discus_core.sv
// Directed bench for discus_core: programs loaded and results read back through the snoop port.
module tb_discus_core;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       snoopp = 1'b0;
   logic       snoopm = 1'b1;
   logic [7:0] snoopa = 8'h00;
   logic [7:0] snoopd = 8'h00;
   logic [7:0] snoopq;

   int vectors     = 0;
   int miscompares = 0;
   logic [7:0] exp_q [$];
   logic [7:0] prog  [$];

   discus_core dut (
      .clk       (clk),
      .reset     (reset),
      .snoop_clk (clk),
      .snoopa    (snoopa),
      .snoopd    (snoopd),
      .snoopq    (snoopq),
      .snoopm    (snoopm),
      .snoopp    (snoopp)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag);
      logic [7:0] e;
      e = exp_q.pop_front();
      vectors++;
      assert (snoopq === e) else begin
         miscompares++;
         $error("FAIL %s: snoopq=%02h expected %02h", tag, snoopq, e);
      end
   endtask

   task automatic hold_chk(input logic [7:0] e, input string tag);
      exp_q.push_back(e);
      chk(tag);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      snoopp = 1'b1;
      snoopm = 1'b0;
      snoopa = a;
      snoopd = d;
      @(posedge clk);
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e, input string tag);
      @(negedge clk);
      snoopp = 1'b1;
      snoopm = 1'b1;
      snoopa = a;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      chk(tag);
   endtask

   task automatic load(input logic [7:0] base);
      foreach (prog[i]) wr(base + 8'(i), prog[i]);
   endtask

   // n free-running core edges
   task automatic run(input int n);
      @(negedge clk);
      snoopp = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   // release reset; the first following edge is the first FETCH
   task automatic go(input int n);
      @(negedge clk);
      reset  = 1'b1;
      snoopp = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic rst();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      // reset state of the snoop read register
      repeat (2) @(posedge clk);
      #1;
      hold_chk(8'h00, "reset_q");

      // load during reset, then run
      prog = '{8'h01, 8'h2A, 8'h09, 8'h80, 8'hFF};
      load(8'h00);
      go(20);
      rd(8'h80, 8'h2A, "ldi_sta");
      rd(8'h00, 8'h01, "prog_readback");
      run(3);
      #1;
      hold_chk(8'h01, "q_holds");

      // add, with exact STA timing (3+3+3 cycles)
      rst();
      prog = '{8'h01, 8'h34, 8'h02, 8'h4A, 8'h09, 8'h80, 8'hFF};
      load(8'h00);
      go(8);
      rd(8'h80, 8'h2A, "add_early");
      run(1);
      rd(8'h80, 8'h7E, "add_result");

      // carry taken, then carry not taken
      rst();
      prog = '{8'h01, 8'hC8, 8'h02, 8'h4A, 8'h0E, 8'h0A, 8'h01, 8'h00, 8'hFF,
               8'h00, 8'h09, 8'h81, 8'hFF};
      load(8'h00);
      wr(8'h81, 8'h99);
      go(40);
      rd(8'h81, 8'h12, "carry_taken");
      rst();
      wr(8'h01, 8'h10);
      go(40);
      rd(8'h81, 8'h12, "carry_not_taken");

      // DEC/JNZ loop: 3 + 3*5 + STA write on edge 21
      rst();
      prog = '{8'h01, 8'h03, 8'h11, 8'h0F, 8'h02, 8'h09, 8'h82, 8'hFF, 8'h09, 8'h83};
      load(8'h00);
      wr(8'h82, 8'h55);
      wr(8'h83, 8'h66);
      go(20);
      rd(8'h82, 8'h55, "loop_early");
      run(1);
      rd(8'h82, 8'h00, "loop_sta");
      run(20);
      rd(8'h83, 8'h66, "halt_holds");

      // freeze for 5 clocks mid-loop: STA lands 5 edges later
      rst();
      wr(8'h82, 8'h55);
      go(10);
      for (int k = 0; k < 5; k++) rd(8'(k), prog[k], "freeze_rd");
      run(10);
      rd(8'h82, 8'h55, "freeze_early");
      run(1);
      rd(8'h82, 8'h00, "freeze_sta");

      // reset just before the STA write edge: write discarded, program reruns
      rst();
      wr(8'h82, 8'h55);
      go(19);
      rd(8'h00, 8'h01, "pre_reset_rd");
      run(1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      hold_chk(8'h00, "async_reset_q");
      @(posedge clk);
      @(negedge clk);
      reset  = 1'b1;
      snoopp = 1'b1;
      snoopm = 1'b1;
      snoopa = 8'h82;
      rd(8'h82, 8'h55, "sta_discarded");
      run(20);
      rd(8'h82, 8'h55, "rerun_early");
      run(1);
      rd(8'h82, 8'h00, "rerun_sta");

      // JMP over a trap at 0x02
      rst();
      prog = '{8'h0C, 8'h10, 8'h01, 8'hEE, 8'h09, 8'h84, 8'hFF, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      load(8'h00);
      prog = '{8'h01, 8'h5A, 8'h09, 8'h84, 8'hFF};
      load(8'h10);
      wr(8'h84, 8'h33);
      go(8);
      rd(8'h84, 8'h33, "jmp_early");
      run(1);
      rd(8'h84, 8'h5A, "jmp_path");

      // operand of an instruction at 0xFF comes from 0x00
      rst();
      wr(8'h00, 8'h0C);
      wr(8'h01, 8'hFF);
      wr(8'hFF, 8'h0C);
      prog = '{8'h01, 8'h77, 8'h09, 8'h86, 8'hFF};
      load(8'h0C);
      wr(8'h86, 8'h33);
      go(30);
      rd(8'h86, 8'h77, "pc_wrap");

      // ALU, flags and remaining branches
      rst();
      prog = '{8'h01, 8'hF0, 8'h04, 8'h3C, 8'h05, 8'h03, 8'h06, 8'hFF,
               8'h09, 8'h90, 8'h03, 8'hCD, 8'h10, 8'h0E, 8'h11, 8'hFF,
               8'hFF, 8'h09, 8'h91, 8'h0D, 8'h17, 8'hFF, 8'hFF, 8'h01,
               8'h81, 8'h12, 8'h13, 8'h11, 8'h0E, 8'h15, 8'h14, 8'h08,
               8'h90, 8'h0A, 8'h9F, 8'h09, 8'h92, 8'h02, 8'h00, 8'h0F,
               8'h2B, 8'hFF, 8'hFF, 8'h13, 8'h07, 8'h09, 8'h93, 8'hFF};
      load(8'h00);
      for (int k = 0; k < 4; k++) wr(8'h90 + 8'(k), 8'hAA);
      wr(8'h9F, 8'h40);
      go(200);
      rd(8'h90, 8'hCC, "logic_ops");
      rd(8'h91, 8'h00, "subi_inc_jc");
      rd(8'h92, 8'h0C, "lda_add");
      rd(8'h93, 8'h06, "shifts_jnz");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
